hazard_unit: RTL
================

Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage core (F/D/E/M/W), downstream of the main decoder.
- Consumes decode-stage control bits and register indices.
- Keeps its own shadow copy of in-flight destination registers per stage.
- Produces stall, bubble and flush enables, plus E-stage operand forwarding selects.
- Also sequences the multi-cycle multiply occupancy of E.

Parameters:
MUL_LAT, 3, cycles a MUL occupies E (legal 1..16; 1 = single-cycle, never busy)
REG_W, 5, register index width

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  asynchronous, active-low; clears all state when 0
rs1D  in  REG_W  source 1 of instruction in D
rs2D  in  REG_W  source 2 of instruction in D
rdD  in  REG_W  destination of instruction in D
RegWriteD  in  1  D instruction writes rd
LoadD  in  1  D instruction is a load
MulD  in  1  D instruction is MUL
RedirectE  in  1  control redirect resolved in E (flush younger D and E)
StallF  out  1  hold PC
StallD  out  1  hold F/D register
StallE  out  1  hold D/E register
FlushD  out  1  clear F/D register
FlushE  out  1  load bubble into D/E register
FlushM  out  1  load bubble into E/M register
ForwardAE  out  2  E operand A select: 00 regfile, 01 W result, 10 M result
ForwardBE  out  2  E operand B select, same encoding

Behaviour:
- Shadow stages E, M, W: each holds {rd, rs1, rs2, RegWrite, Load, Mul}; rs1/rs2 are kept in E only.
- Shadow reset: all fields 0; a bubble is all fields 0.
- Shadow E update:
  - StallE: hold.
  - FlushE: bubble.
  - Otherwise: load D fields.
- Shadow M update: bubble if FlushM, otherwise load E. Shadow W always loads M.
- Multiply sequencer states: IDLE, BUSY. Counter cnt is $clog2(MUL_LAT)+1 bits, reset 0, state resets to IDLE.
  - IDLE -> BUSY when shadow E has Mul=1, MUL_LAT>1 and cnt==0. Entry loads cnt=MUL_LAT-1.
  - BUSY: cnt decrements each cycle. BUSY -> IDLE on the cycle cnt reaches 1; the MUL advances to M on that edge.
  - mulbusy = (state==BUSY) or (IDLE with E Mul=1 and MUL_LAT>1 on its first E cycle). Net effect: a MUL stays in E exactly MUL_LAT cycles.
- Load-use: lduse = E.Load & E.RegWrite & E.rd!=0 & (E.rd==rs1D | E.rd==rs2D).
- Output equations (combinational from shadow/FSM state and inputs):
  - StallE = mulbusy
  - FlushM = mulbusy
  - StallF = StallD = mulbusy | lduse
  - FlushE = ~mulbusy & (lduse | RedirectE)
  - FlushD = ~mulbusy & RedirectE
- RedirectE is ignored while mulbusy. The source holds it until E advances.
- Redirect together with lduse: both flushes win. StallF/StallD still assert, but the flushed D makes this harmless; PC is updated by the redirect path.
- ForwardAE:
  - 10 if M.RegWrite & M.rd!=0 & M.rd==E.rs1;
  - else 01 if W.RegWrite & W.rd!=0 & W.rd==E.rs1;
  - else 00.
  - M has priority. ForwardBE is the same rule using E.rs2.
- x0 never forwards and never triggers a stall.
- Register file writes in the first half-cycle, so no D-stage forwarding is required.
- Reset asserted mid-operation (including BUSY): immediate return to IDLE, cnt=0, all shadows bubble. All outputs read 0 while reset is low.
- Latency: all outputs are valid in the same cycle as the inputs that cause them; no added pipeline delay.

Decomposition:
- Shared package holds:
  - FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - MUL FSM state encoding IDLE/BUSY;
  - shadow stage struct {rd, rs1, rs2, regwrite, load, mul}.
- One sub-module, hz_stage_reg: one shadow stage register with async active-low reset, hold and bubble inputs. Instantiated for E, M and W.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release with all inputs 0 -> all outputs 0, Forward 00.
- Load-use: LW x5 in D, next cycle ADD x6,x5,x1 in D -> exactly 1 cycle of StallF=StallD=FlushE=1. Then ForwardAE=01 for the ADD in E (load result from W).
- Forward priority: ADD x3 then ADD x3 then ADD x4,x3,x3 -> ForwardAE=ForwardBE=10 (M wins over W). With rd=x0 instead -> 00.
- Multiply, MUL_LAT=3: MUL x7 enters E -> StallF/D/E=1 and FlushM=1 for 2 cycles. Dependent ADD x8,x7 then sees ForwardAE=10 in its first E cycle.
- Redirect: RedirectE=1 with no MUL -> FlushD=FlushE=1 for 1 cycle. Shadow E becomes a bubble, so next cycle Forward* is 00 for the squashed slot.
- Mid-BUSY reset: assert reset low in the second MUL cycle -> all outputs 0 immediately. After release, IDLE with no residual stall.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_unit_pkg
// Brief   : Shared types and constants for the pipeline hazard controller:
//           forwarding select encoding, multiply sequencer states and the
//           shadow stage record tracked for E, M and W.
// Revision: 1.0 - initial release
// ============================================================================
package hazard_unit_pkg;

  // Register index width carried in the shadow records
  localparam int HZ_REG_W = 5;

  // E-stage operand source selects
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Multiply occupancy sequencer states
  typedef enum logic [0:0] {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

  // Shadow copy of the control/index fields of one in-flight instruction
  typedef struct packed {
    logic [HZ_REG_W-1:0] rd;
    logic [HZ_REG_W-1:0] rs1;
    logic [HZ_REG_W-1:0] rs2;
    logic                regwrite;
    logic                load;
    logic                mul;
  } hz_stage_t;

  // A bubble carries no write, no load, no multiply and only x0 indices
  localparam hz_stage_t HZ_BUBBLE = '0;

  // Operand source for an E-stage source index; the younger M result wins
  // over W, and x0 is hard-wired so it never forwards.
  function automatic logic [1:0] fwd_select(
    input hz_stage_t           m,
    input hz_stage_t           w,
    input logic [HZ_REG_W-1:0] rs
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (m.regwrite && (m.rd != '0) && (m.rd == rs)) begin
      sel = FWD_M;
    end else if (w.regwrite && (w.rd != '0) && (w.rd == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage : hazard_unit_pkg
`default_nettype wire

// File: rtl/hazard_unit_stage_reg.sv
`default_nettype none
// ============================================================================
// Module  : hz_stage_reg
// Brief   : One shadow pipeline stage register. Hold keeps the current
//           record, bubble loads an empty record, otherwise the upstream
//           record is captured. Asynchronous active-low reset to a bubble.
// Revision: 1.0 - initial release
// ============================================================================
module hz_stage_reg
  import hazard_unit_pkg::*;
(
  input  logic      clk,
  input  logic      rst_ni,
  input  logic      hold_i,
  input  logic      bubble_i,
  input  hz_stage_t d_i,
  output hz_stage_t q_o
);

  hz_stage_t stage_q;
  hz_stage_t stage_d;

  // Next record: hold has priority over bubble, bubble over a normal load
  always_comb begin
    stage_d = d_i;
    if (hold_i) begin
      stage_d = stage_q;
    end else if (bubble_i) begin
      stage_d = HZ_BUBBLE;
    end
  end

  // Stage storage, cleared to a bubble while reset is low
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= HZ_BUBBLE;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q;

endmodule : hz_stage_reg
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module  : hazard_unit
// Brief   : Hazard controller for the 5-stage core. Tracks shadow E/M/W
//           records, detects load-use and multiply occupancy, and drives
//           the stall/flush enables and the E-stage forwarding selects.
//           All outputs are combinational from shadow state and D inputs.
//           REG_W must equal the package record width HZ_REG_W; MUL_LAT
//           is legal from 1 to 16.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int REG_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs1D,
  input  logic [REG_W-1:0] rs2D,
  input  logic [REG_W-1:0] rdD,
  input  logic             RegWriteD,
  input  logic             LoadD,
  input  logic             MulD,
  input  logic             RedirectE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE
);

  // Counter is wide enough to hold MUL_LAT-1 plus headroom
  localparam int              CNT_W     = $clog2(MUL_LAT) + 1;
  localparam logic            MUL_MULTI = (MUL_LAT > 1);
  // Only latencies of 3+ need cycles in BUSY beyond the first E cycle
  localparam logic            MUL_LONG  = (MUL_LAT > 2);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2);

  // --------------------------------------------------------------------------
  // Shadow pipeline records
  // --------------------------------------------------------------------------
  hz_stage_t d_rec;
  hz_stage_t e_q;
  hz_stage_t m_q;
  hz_stage_t w_q;
  hz_stage_t m_in;

  logic mulbusy;
  logic lduse;
  logic flush_e_int;

  // Pack the decode-stage fields into a shadow record
  always_comb begin
    d_rec          = HZ_BUBBLE;
    d_rec.rd       = rdD;
    d_rec.rs1      = rs1D;
    d_rec.rs2      = rs2D;
    d_rec.regwrite = RegWriteD;
    d_rec.load     = LoadD;
    d_rec.mul      = MulD;
  end

  // Sources are only needed while in E, so M and W drop them
  always_comb begin
    m_in     = e_q;
    m_in.rs1 = '0;
    m_in.rs2 = '0;
  end

  hz_stage_reg u_stage_e (
    .clk      (clk),
    .rst_ni   (reset),
    .hold_i   (mulbusy),
    .bubble_i (flush_e_int),
    .d_i      (d_rec),
    .q_o      (e_q)
  );

  hz_stage_reg u_stage_m (
    .clk      (clk),
    .rst_ni   (reset),
    .hold_i   (1'b0),
    .bubble_i (mulbusy),
    .d_i      (m_in),
    .q_o      (m_q)
  );

  hz_stage_reg u_stage_w (
    .clk      (clk),
    .rst_ni   (reset),
    .hold_i   (1'b0),
    .bubble_i (1'b0),
    .d_i      (m_q),
    .q_o      (w_q)
  );

  // --------------------------------------------------------------------------
  // Multiply occupancy sequencer
  // The first E cycle of a MUL is recognised in IDLE with cnt==0. For
  // latencies of 3+ the sequencer spends cycles 2..MUL_LAT-1 in BUSY and
  // returns to IDLE with cnt==1, which marks the MUL's final E cycle so it
  // is not mistaken for a fresh MUL. Any IDLE cycle without a start clears
  // cnt, so a back-to-back MUL entering E next is recognised again.
  // --------------------------------------------------------------------------
  mul_state_e       state_q;
  mul_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             mul_start;

  assign mul_start = e_q.mul & MUL_MULTI & (cnt_q == '0);

  // Sequencer state and countdown registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sequencer next state and countdown
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MUL_IDLE: begin
        if (mul_start) begin
          cnt_d = CNT_LOAD;
          if (MUL_LONG) begin
            state_d = MUL_BUSY;
          end
        end else begin
          cnt_d = '0;
        end
      end
      MUL_BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = MUL_IDLE;
        end
      end
      default: begin
        state_d = MUL_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer output: E is occupied by a MUL that must not advance yet
  always_comb begin
    mulbusy = 1'b0;
    case (state_q)
      MUL_IDLE: mulbusy = mul_start;
      MUL_BUSY: mulbusy = 1'b1;
      default:  mulbusy = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Hazard detection and output enables
  // --------------------------------------------------------------------------

  // Load in E whose destination is read by the instruction in D
  always_comb begin
    lduse = e_q.load & e_q.regwrite & (e_q.rd != '0) &
            ((e_q.rd == rs1D) | (e_q.rd == rs2D));
  end

  // A redirect or load-use squashes E, except while a MUL holds E
  assign flush_e_int = ~mulbusy & (lduse | RedirectE);

  // Stall, flush and forwarding outputs, forced quiet while in reset
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (reset) begin
      StallE    = mulbusy;
      FlushM    = mulbusy;
      StallF    = mulbusy | lduse;
      StallD    = mulbusy | lduse;
      FlushE    = flush_e_int;
      FlushD    = ~mulbusy & RedirectE;
      ForwardAE = fwd_select(m_q, w_q, e_q.rs1);
      ForwardBE = fwd_select(m_q, w_q, e_q.rs2);
    end
  end

  // Fields that the downstream shadow stages carry but nothing consumes
  logic unused_fields;
  assign unused_fields = ^{m_q.rs1, m_q.rs2, m_q.load, m_q.mul,
                           w_q.rs1, w_q.rs2, w_q.load, w_q.mul};

endmodule : hazard_unit
`default_nettype wire
